// File: rtl/des_key_sched_if.sv
// des_key_sched_if: key-load / round-request handshake and subkey output bundle
interface des_key_sched_if;
  logic [63:0] key_in;
  logic        key_in_valid;
  logic        decrypt_in;
  logic        round_req_in;
  logic [47:0] key_data_out;
  logic        key_data_out_valid;
  logic [3:0]  round_num_out;
  logic        key_busy_out;
  logic        key_done_out;
  modport master (
    output key_in, key_in_valid, decrypt_in, round_req_in,
    input  key_data_out, key_data_out_valid, round_num_out, key_busy_out, key_done_out
  );
  modport slave (
    input  key_in, key_in_valid, decrypt_in, round_req_in,
    output key_data_out, key_data_out_valid, round_num_out, key_busy_out, key_done_out
  );
endinterface

// File: rtl/des_key_sched.sv
// des_key_sched: DES round-key generator; PC-1 at load, per-request C/D rotation and PC-2 subkey
module des_key_sched (
  input  logic           clk_in,
  input  logic           rst_n_in,
  des_key_sched_if.slave bus
);
  typedef enum logic {IDLE, ARMED} state_t;
  state_t      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d, c_rot, d_rot;
  logic [3:0]  rnd_q, rnd_d, rnd_nxt, num_q, num_d;
  logic [47:0] key_q, key_d;
  logic        dec_q, dec_d, vld_q, vld_d, done_q, done_d;
  logic        one, zero;
  // Key bit n (DES numbering, 1 = MSB) lives at key_in[64-n]
  function automatic logic [55:0] pc1(input logic [63:0] k);
    return {k[7],  k[15], k[23], k[31], k[39], k[47], k[55], k[63],
            k[6],  k[14], k[22], k[30], k[38], k[46], k[54], k[62],
            k[5],  k[13], k[21], k[29], k[37], k[45], k[53], k[61],
            k[4],  k[12], k[20], k[28],
            k[1],  k[9],  k[17], k[25], k[33], k[41], k[49], k[57],
            k[2],  k[10], k[18], k[26], k[34], k[42], k[50], k[58],
            k[3],  k[11], k[19], k[27], k[35], k[43], k[51], k[59],
            k[36], k[44], k[52], k[60]};
  endfunction
  // CD bit n (1 = C[27]) lives at cd[56-n]
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    return {cd[42], cd[39], cd[45], cd[32], cd[55], cd[51], cd[53], cd[28],
            cd[41], cd[50], cd[35], cd[46], cd[33], cd[37], cd[44], cd[52],
            cd[30], cd[48], cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
            cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],  cd[26], cd[16],
            cd[5],  cd[11], cd[23], cd[8],  cd[12], cd[7],  cd[17], cd[0],
            cd[22], cd[3],  cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]};
  endfunction
  function automatic logic [27:0] rot(input logic [27:0] x, input logic dec, input logic z, input logic o);
    return z ? x : dec ? (o ? {x[0], x[27:1]} : {x[1:0], x[27:2]})
                       : (o ? {x[26:0], x[27]} : {x[25:0], x[27:26]});
  endfunction
  // Single-step rounds are 1,2,9,16 encrypting; decrypt round 1 uses the unshifted halves
  assign one     = rnd_q == 4'd0 || rnd_q == 4'd1 || rnd_q == 4'd8 || rnd_q == 4'd15;
  assign zero    = dec_q && rnd_q == 4'd0;
  assign c_rot   = rot(c_q, dec_q, zero, one);
  assign d_rot   = rot(d_q, dec_q, zero, one);
  assign rnd_nxt = rnd_q + 4'd1;
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    rnd_d   = rnd_q;
    dec_d   = dec_q;
    key_d   = key_q;
    num_d   = num_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    if (bus.key_in_valid) begin
      {c_d, d_d} = pc1(bus.key_in);
      rnd_d      = 4'd0;
      dec_d      = bus.decrypt_in;
      state_d    = ARMED;
    end else if (state_q == ARMED && bus.round_req_in) begin
      c_d     = c_rot;
      d_d     = d_rot;
      key_d   = pc2({c_rot, d_rot});
      num_d   = rnd_nxt;
      rnd_d   = rnd_nxt;
      vld_d   = 1'b1;
      done_d  = rnd_q == 4'd15;
      state_d = rnd_q == 4'd15 ? IDLE : ARMED;
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      rnd_q   <= '0;
      dec_q   <= 1'b0;
      key_q   <= '0;
      num_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      rnd_q   <= rnd_d;
      dec_q   <= dec_d;
      key_q   <= key_d;
      num_q   <= num_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end
  assign bus.key_data_out       = key_q;
  assign bus.key_data_out_valid = vld_q;
  assign bus.round_num_out      = num_q;
  assign bus.key_busy_out       = state_q == ARMED;
  assign bus.key_done_out       = done_q;
endmodule

// File: tb/tb_des_key_sched.sv
// tb_des_key_sched: directed stimulus with a reference key-schedule model feeding a scoreboard queue
module tb_des_key_sched;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  des_key_sched_if bus ();
  des_key_sched dut (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus));
  always #5 clk_in = ~clk_in;
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  logic [47:0] mk [16];
  logic [52:0] sb [$];
  logic        m_armed = 1'b0, m_dec = 1'b0;
  logic [4:0]  m_rnd = '0;
  logic [47:0] last_key = '0;
  logic [3:0]  last_num = '0;
  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  // Forward schedule straight from the FIPS tables using 1-based bit numbers
  task automatic build(input logic [63:0] k);
    logic [55:0] cd;
    logic [27:0] c, d;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SH_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) mk[r][47-j] = cd[56-PC2_T[j]];
    end
  endtask
  task automatic check_outputs();
    logic [52:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("valid", {63'd0, bus.key_data_out_valid}, 64'd1);
      chk("key", {16'd0, bus.key_data_out}, {16'd0, e[47:0]});
      chk("round", {60'd0, bus.round_num_out}, {60'd0, e[51:48]});
      chk("done", {63'd0, bus.key_done_out}, {63'd0, e[52]});
      last_key = e[47:0];
      last_num = e[51:48];
    end else begin
      chk("no_valid", {63'd0, bus.key_data_out_valid}, 64'd0);
      chk("no_done", {63'd0, bus.key_done_out}, 64'd0);
      chk("key_hold", {16'd0, bus.key_data_out}, {16'd0, last_key});
      chk("round_hold", {60'd0, bus.round_num_out}, {60'd0, last_num});
    end
    chk("busy", {63'd0, bus.key_busy_out}, {63'd0, m_armed});
  endtask
  task automatic drive(input logic ld, input logic dc, input logic [63:0] k, input logic rq);
    bus.key_in_valid = ld;
    bus.decrypt_in   = dc;
    bus.key_in       = k;
    bus.round_req_in = rq;
    if (ld) begin
      build(k);
      m_armed = 1'b1;
      m_rnd   = '0;
      m_dec   = dc;
    end else if (rq && m_armed) begin
      m_rnd = m_rnd + 5'd1;
      sb.push_back({m_rnd == 5'd16, m_rnd[3:0], mk[m_dec ? 16 - int'(m_rnd) : int'(m_rnd) - 1]});
      if (m_rnd == 5'd16) m_armed = 1'b0;
    end
    @(posedge clk_in);
    #2;
    bus.key_in_valid = 1'b0;
    bus.round_req_in = 1'b0;
    check_outputs();
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_key"}, {16'd0, bus.key_data_out}, 64'd0);
    chk({tag, "_valid"}, {63'd0, bus.key_data_out_valid}, 64'd0);
    chk({tag, "_round"}, {60'd0, bus.round_num_out}, 64'd0);
    chk({tag, "_busy"}, {63'd0, bus.key_busy_out}, 64'd0);
    chk({tag, "_done"}, {63'd0, bus.key_done_out}, 64'd0);
  endtask
  initial begin
    bus.key_in = '0;
    bus.key_in_valid = 1'b0;
    bus.decrypt_in = 1'b0;
    bus.round_req_in = 1'b0;
    #12;
    check_reset_outputs("reset");
    #11 rst_n_in = 1'b1;
    @(posedge clk_in);
    #2;
    // Requests with no key loaded
    drive(0, 0, 64'd0, 1);
    drive(0, 0, 64'd0, 1);
    // Encrypt order, back-to-back
    drive(1, 0, 64'h133457799BBCDFF1, 0);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 64'd0, 1);
      if (i == 1) chk("enc_k1_vec", {16'd0, bus.key_data_out}, 64'h1B02EFFC7072);
      if (i == 2) chk("enc_k2_vec", {16'd0, bus.key_data_out}, 64'h79AED9DBC9E5);
      if (i == 16) chk("enc_k16_vec", {16'd0, bus.key_data_out}, 64'hCB3D8B0E17F5);
    end
    drive(0, 0, 64'd0, 1);
    drive(0, 0, 64'd0, 0);
    // Decrypt order with random idle gaps
    drive(1, 1, 64'h133457799BBCDFF1, 0);
    for (int i = 1; i <= 16; i++) begin
      repeat ($urandom_range(0, 3)) drive(0, 0, 64'd0, 0);
      drive(0, 0, 64'd0, 1);
      if (i == 1) chk("dec_first_vec", {16'd0, bus.key_data_out}, 64'hCB3D8B0E17F5);
      if (i == 16) chk("dec_last_vec", {16'd0, bus.key_data_out}, 64'h1B02EFFC7072);
    end
    // Parity bits alone give an all-zero schedule
    drive(1, 0, 64'h0101010101010101, 0);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 64'd0, 1);
      chk("parity_zero", {16'd0, bus.key_data_out}, 64'd0);
    end
    drive(1, 1, 64'h0000000000000000, 0);
    for (int i = 1; i <= 16; i++) drive(0, 0, 64'd0, 1);
    // Reload collides with a request mid-run
    drive(1, 0, 64'h133457799BBCDFF1, 0);
    for (int i = 1; i <= 5; i++) drive(0, 0, 64'd0, 1);
    drive(1, 0, 64'h0E329232EA6D0D73, 1);
    for (int i = 1; i <= 16; i++) drive(0, 0, 64'd0, 1);
    // Asynchronous reset during round 8
    drive(1, 0, 64'h133457799BBCDFF1, 0);
    for (int i = 1; i <= 8; i++) drive(0, 0, 64'd0, 1);
    #3 rst_n_in = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    m_armed = 1'b0;
    m_rnd = '0;
    last_key = '0;
    last_num = '0;
    sb.delete();
    #2 rst_n_in = 1'b1;
    @(posedge clk_in);
    #2;
    drive(0, 0, 64'd0, 1);
    drive(0, 0, 64'd0, 1);
    drive(1, 1, 64'h0E329232EA6D0D73, 0);
    for (int i = 1; i <= 3; i++) drive(0, 0, 64'd0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
